// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the five-stage pipeline: load-use bubbles, branch squash,
// data-memory wait freezing with a sticky timeout trap, and a saturating stall counter.
module pipeline_hazard_controller #(
   parameter int REG_W       = 4,
   parameter int MEM_TIMEOUT = 15,
   parameter int TO_W        = 4,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_uses_rs1,
   input  logic             id_uses_rs2,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             id_ex_en,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_count,
   output logic [1:0]       fsm_state
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      HALT     = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [TO_W-1:0]   wait_q, wait_d;
   logic              timeout_q, timeout_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   logic lu;
   logic mem_stall;
   logic run_decode;

   // Memory handshake: mem_req marks an outstanding access; the access completes in
   // the cycle mem_ready is high. Until then every stage is frozen.
   assign mem_stall = mem_req && !mem_ready;

   assign lu = ex_mem_read && (ex_rd != '0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));

   // The release cycle of a memory wait behaves like RUN with no memory stall.
   assign run_decode = ((state_q == RUN) && !mem_stall) ||
                       ((state_q == MEM_WAIT) && mem_ready);

   always_comb begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_en    = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      if (reset && run_decode) begin
         pc_en     = 1'b1;
         if_id_en  = 1'b1;
         id_ex_en  = 1'b1;
         ex_mem_en = 1'b1;
         mem_wb_en = 1'b1;
         if (ex_branch_taken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (lu) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      wait_d    = wait_q;
      timeout_d = timeout_q;
      case (state_q)
         RUN: begin
            if (mem_stall) begin
               state_d = MEM_WAIT;
               wait_d  = TO_W'(1);
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               state_d = RUN;
               wait_d  = '0;
            end else if (wait_q == TO_W'(MEM_TIMEOUT)) begin
               state_d   = HALT;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + TO_W'(1);
            end
         end
         HALT: begin
            state_d   = HALT;
            timeout_d = 1'b1;
         end
         default: begin
            state_d = RUN;
            wait_d  = '0;
         end
      endcase
   end

   always_comb begin
      cnt_d = cnt_q;
      if (!pc_en && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= RUN;
         wait_q    <= '0;
         timeout_q <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         timeout_q <= timeout_d;
         cnt_q     <= cnt_d;
      end
   end

   assign mem_timeout = timeout_q;
   assign stall_count = cnt_q;
   assign fsm_state   = state_q;

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
- Central sequencer for the five-stage pipeline registers: IF/ID, ID/EX, EX/MEM and MEM/WB.
- Drives the PC enable plus a per-boundary enable and flush for each pipeline register.
- Resolves three events: load-use hazards, taken branches, and multi-cycle data-memory waits.
- Provides a sticky memory-timeout trap and a saturating stall counter for performance and debug.

Parameters:
- REG_W, 4, width of register indices.
- MEM_TIMEOUT, 15, maximum consecutive memory-wait cycles before trapping (legal range 1..2^TO_W-1).
- TO_W, 4, width of the wait counter.
- CNT_W, 16, width of stall_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- id_rs1  in  REG_W  source register 1 of the instruction in ID.
- id_rs2  in  REG_W  source register 2 of the instruction in ID.
- id_uses_rs1  in  1  ID instruction reads rs1.
- id_uses_rs2  in  1  ID instruction reads rs2.
- ex_rd  in  REG_W  destination register of the instruction in EX.
- ex_mem_read  in  1  EX instruction is a load.
- ex_branch_taken  in  1  branch resolved taken in EX.
- mem_req  in  1  MEM stage has an outstanding data-memory access.
- mem_ready  in  1  data memory completes the access this cycle.
- pc_en  out  1  PC update enable.
- if_id_en  out  1  IF/ID register enable.
- id_ex_en  out  1  ID/EX register enable.
- ex_mem_en  out  1  EX/MEM register enable.
- mem_wb_en  out  1  MEM/WB register enable.
- if_id_flush  out  1  load a bubble into IF/ID.
- id_ex_flush  out  1  load a bubble into ID/EX.
- mem_timeout  out  1  sticky trap flag.
- stall_count  out  CNT_W  saturating count of stall cycles.

Behaviour:
- Reset low: state=RUN, wait counter=0, stall_count=0, mem_timeout=0, all enables=0, all flushes=0. Reset overrides any state, including mid-MEM_WAIT and HALT.
- Enables and flushes are combinational from state and current inputs. State, wait counter, mem_timeout and stall_count are registered.
- Load-use hazard (lu) = ex_mem_read && ex_rd!=0 && ((id_uses_rs1 && id_rs1==ex_rd) || (id_uses_rs2 && id_rs2==ex_rd)).
- mem_stall = mem_req && !mem_ready.
- FSM states: RUN, MEM_WAIT, HALT.
- RUN, decoded in priority order:
  - mem_stall: all five enables=0, flushes=0. Next state MEM_WAIT with wait counter=1.
  - ex_branch_taken: all enables=1, if_id_flush=1, id_ex_flush=1. Branch takes priority over lu because the ID instruction is squashed.
  - lu: pc_en=0, if_id_en=0, id_ex_flush=1, all other enables=1. Inserts exactly one bubble; state stays RUN.
  - Otherwise: all enables=1, flushes=0.
- MEM_WAIT:
  - mem_ready=1: release cycle. Outputs use the RUN decode with the mem_stall term forced false, so a held branch or lu applies here. Next state RUN, wait counter cleared.
  - mem_ready=0: all enables=0, flushes=0, wait counter increments.
  - If the counter equals MEM_TIMEOUT and mem_ready=0: next state HALT, mem_timeout set to 1.
- HALT: all enables=0, flushes=0, mem_timeout held at 1. Exit is by reset only; mem_ready is ignored.
- Inputs from frozen stages are held stable by the datapath during MEM_WAIT. The controller does not latch them.
- stall_count increments on every cycle with pc_en=0 while reset is high (lu, MEM_WAIT, HALT). It saturates at 2^CNT_W-1 with no wrap.
- A flush has priority over enable on the same register. When a flush is asserted, the matching enable is also 1 so the bubble is loaded.

Test Plan:
- Release reset with all inputs 0 -> cycle 1: all enables=1, flushes=0, stall_count=0, mem_timeout=0.
- ex_mem_read=1, ex_rd=3, id_rs2=3, id_uses_rs2=1 for one cycle -> that cycle: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Next cycle normal; stall_count=1. Same stimulus with ex_rd=0 -> no stall.
- lu and ex_branch_taken in the same cycle -> pc_en=1, if_id_flush=1, id_ex_flush=1, stall_count unchanged.
- mem_req=1, mem_ready=0 for 3 cycles, then mem_ready=1 with ex_branch_taken=1 -> 3 cycles all enables 0, release cycle shows branch flush, stall_count=3, state returns to RUN.
- MEM_TIMEOUT=15, mem_req=1, mem_ready never -> mem_timeout=1 after the 16th frozen cycle. Later mem_ready=1 changes nothing. Reset low mid-HALT -> all outputs 0 asynchronously, RUN after release.
- Force stall_count near max (CNT_W=4, 17 stall cycles) -> stall_count holds at 15.
